// File: rtl/led_effect_pkg.sv
// Shared definitions for the LED pattern engine.
// Contents:
//   mode_e  - pattern mode encoding, driven straight from the 2-bit mode pin.
package led_effect_pkg;

    typedef enum logic [1:0] {
        MODE_BOUNCE = 2'd0,
        MODE_ROTL   = 2'd1,
        MODE_ROTR   = 2'd2,
        MODE_FILL   = 2'd3
    } mode_e;

endpackage

// File: rtl/led_chaser_prescaler.sv
// Programmable step prescaler for the LED pattern engine.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   en     in   1 = count, 0 = freeze the counter
//   div    in   step period minus one, in clocks
//   fire   out  combinational: this edge is a pattern step edge
//   tick   out  registered one-clock pulse, high after each step edge
module led_prescaler #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             fire,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    // Compare with >= so that lowering div below the running count wraps at once.
    always_comb begin
        fire   = en && (cnt_q >= div);
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (en) begin
            if (fire) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d  = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_chaser.sv
// LED pattern engine: WIDTH-bit pattern register stepped by the prescaler.
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-high reset
//   en     in   1 = prescaler runs, 0 = everything frozen
//   mode   in   0 bounce, 1 rotate-left, 2 rotate-right, 3 fill/drain
//   div    in   step period minus one, in clocks
//   q      out  LED pattern, registered
//   dir    out  1 = toward MSB / filling, 0 = toward LSB / draining
//   tick   out  one-clock pulse coincident with each pattern update
//
// Pattern FSM state is the latched mode (mode_q):
//   state        | meaning
//   MODE_BOUNCE  | single dot sweeping LSB<->MSB
//   MODE_ROTL    | single dot rotating toward MSB
//   MODE_ROTR    | single dot rotating toward LSB
//   MODE_FILL    | bar filling from LSB, then draining from LSB
module led_chaser
    import led_effect_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] q,
    output logic             dir,
    output logic             tick
);

    localparam logic [WIDTH-1:0] LSB_DOT  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MSB_DOT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic             fire;
    mode_e            mode_in;
    mode_e            mode_q, mode_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dir_q, dir_d;
    logic             bounce_dn;
    logic             fill_dn;

    led_prescaler #(
        .DIV_W (DIV_W)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .div   (div),
        .fire  (fire),
        .tick  (tick)
    );

    assign mode_in = mode_e'(mode);

    // Direction for the next step; end stops override the stored direction.
    always_comb begin
        bounce_dn = dir_q;
        if (q_q[WIDTH-1]) begin
            bounce_dn = 1'b0;
        end else if (q_q[0]) begin
            bounce_dn = 1'b1;
        end

        fill_dn = dir_q;
        if (q_q == ALL_ONES) begin
            fill_dn = 1'b0;
        end else if (q_q == '0) begin
            fill_dn = 1'b1;
        end
    end

    always_comb begin
        mode_d = mode_q;
        q_d    = q_q;
        dir_d  = dir_q;

        if (fire) begin
            if (mode_in != mode_q) begin
                // Mode change: load the new mode's seed instead of stepping.
                mode_d = mode_in;
                case (mode_in)
                    MODE_BOUNCE: begin q_d = LSB_DOT; dir_d = 1'b1; end
                    MODE_ROTL:   begin q_d = LSB_DOT; dir_d = 1'b1; end
                    MODE_ROTR:   begin q_d = MSB_DOT; dir_d = 1'b0; end
                    default:     begin q_d = '0;      dir_d = 1'b1; end
                endcase
            end else begin
                case (mode_q)
                    MODE_BOUNCE: begin
                        if (q_q == '0) begin
                            q_d   = LSB_DOT;
                            dir_d = 1'b1;
                        end else begin
                            q_d   = bounce_dn ? (q_q << 1) : (q_q >> 1);
                            dir_d = bounce_dn;
                        end
                    end
                    MODE_ROTL: begin
                        if (q_q == '0) begin
                            q_d   = LSB_DOT;
                            dir_d = 1'b1;
                        end else begin
                            q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                        end
                    end
                    MODE_ROTR: begin
                        if (q_q == '0) begin
                            q_d   = MSB_DOT;
                            dir_d = 1'b0;
                        end else begin
                            q_d = {q_q[0], q_q[WIDTH-1:1]};
                        end
                    end
                    default: begin
                        // Empty bar is a legal fill state, so no recovery here.
                        q_d   = {q_q[WIDTH-2:0], fill_dn};
                        dir_d = fill_dn;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_BOUNCE;
            q_q    <= LSB_DOT;
            dir_q  <= 1'b1;
        end else begin
            mode_q <= mode_d;
            q_q    <= q_d;
            dir_q  <= dir_d;
        end
    end

    assign q   = q_q;
    assign dir = dir_q;

endmodule

// File: tb/tb_led_chaser.sv
module tb_led_chaser;

    localparam int W     = 8;
    localparam int DIV_W = 24;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [W-1:0]     q;
    logic             dir;
    logic             tick;

    logic             en2   = 1'b1;
    logic [1:0]       mode2 = 2'd0;
    logic [DIV_W-1:0] div2  = '0;
    logic [1:0]       q2;
    logic             dir2;
    logic             tick2;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: dot position / bar length instead of bit vectors.
    int m_cnt;
    int m_mode_r;
    int m_pos;
    int m_len;
    int m_dir;
    int m_tick;
    int m2_q;

    always #5 clk = ~clk;

    led_chaser #(.WIDTH(W), .DIV_W(DIV_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .div   (div),
        .q     (q),
        .dir   (dir),
        .tick  (tick)
    );

    led_chaser #(.WIDTH(2), .DIV_W(DIV_W)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .en    (en2),
        .mode  (mode2),
        .div   (div2),
        .q     (q2),
        .dir   (dir2),
        .tick  (tick2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] exp_q();
        int mask;
        if (m_mode_r == 3) begin
            mask = (1 << m_len) - 1;
            if (m_dir == 1) return W'(mask);
            return W'(mask << (W - m_len));
        end
        return W'(1 << m_pos);
    endfunction

    task automatic model_reset();
        m_cnt    = 0;
        m_mode_r = 0;
        m_pos    = 0;
        m_len    = 0;
        m_dir    = 1;
        m_tick   = 0;
        m2_q     = 1;
    endtask

    task automatic model_fire(input int md);
        if (md != m_mode_r) begin
            m_mode_r = md;
            case (md)
                0, 1: begin m_pos = 0;     m_dir = 1; end
                2:    begin m_pos = W - 1; m_dir = 0; end
                default: begin m_len = 0;  m_dir = 1; end
            endcase
        end else begin
            case (m_mode_r)
                0: begin
                    if (m_pos == W - 1) m_dir = 0;
                    else if (m_pos == 0) m_dir = 1;
                    m_pos = (m_dir == 1) ? m_pos + 1 : m_pos - 1;
                end
                1: m_pos = (m_pos + 1) % W;
                2: m_pos = (m_pos + W - 1) % W;
                default: begin
                    if (m_dir == 1) begin
                        if (m_len == W) begin m_dir = 0; m_len = W - 1; end
                        else m_len = m_len + 1;
                    end else begin
                        if (m_len == 0) begin m_dir = 1; m_len = 1; end
                        else m_len = m_len - 1;
                    end
                end
            endcase
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else begin
            m_tick = 0;
            m2_q   = (m2_q == 1) ? 2 : 1;
            if (en) begin
                if (m_cnt >= int'(div)) begin
                    m_cnt  = 0;
                    m_tick = 1;
                    model_fire(int'(mode));
                end else begin
                    m_cnt++;
                end
            end
        end
        #1;
        check_val("q",    32'(q),    32'(exp_q()));
        check_val("dir",  32'(dir),  32'(m_dir));
        check_val("tick", 32'(tick), 32'(m_tick));
        check_val("q_w2", 32'(q2),   32'(m2_q));
    endtask

    logic [W-1:0] bounce_seq [15];

    initial begin
        bounce_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                       8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
        reset = 1'b1;
        en    = 1'b1;
        mode  = 2'd0;
        div   = '0;
        model_reset();
        #2;
        check_val("rst_q",    32'(q),    32'h01);
        check_val("rst_dir",  32'(dir),  32'd1);
        check_val("rst_tick", 32'(tick), 32'd0);
        cycle();
        reset = 1'b0;

        // Bounce at full rate with fixed expected sequence.
        for (int i = 0; i < 15; i++) begin
            cycle();
            check_val("bounce_seq", 32'(q), 32'(bounce_seq[i]));
        end

        // Slow tick, then freeze with en=0, then resume.
        div = 24'd3;
        repeat (12) cycle();
        en = 1'b0;
        repeat (10) cycle();
        en = 1'b1;
        repeat (9) cycle();

        // Switch bounce -> rotate-right while the dot sits on bit 3.
        div  = '0;
        mode = 2'd0;
        for (int i = 0; i < 40 && !(m_mode_r == 0 && m_pos == 3); i++) cycle();
        check_val("at_08", 32'(q), 32'h08);
        mode = 2'd2;
        cycle();
        check_val("rotr_seed_q",   32'(q),   32'h80);
        check_val("rotr_seed_dir", 32'(dir), 32'd0);
        repeat (10) cycle();

        // Fill/drain: seed is an empty bar, full period is 16 steps.
        mode = 2'd3;
        cycle();
        check_val("fill_seed", 32'(q), 32'h00);
        repeat (17) cycle();
        check_val("fill_period", 32'(q), 32'h01);

        // Mode toggled away and back between step edges: no reload.
        mode = 2'd0;
        cycle();
        div = 24'd3;
        for (int i = 0; i < 8 && m_cnt != 0; i++) cycle();
        cycle();
        mode = 2'd1;
        cycle();
        mode = 2'd0;
        repeat (6) cycle();

        // Asynchronous reset in the middle of a count, checked before any edge.
        #3;
        reset = 1'b1;
        #1;
        check_val("async_q",    32'(q),    32'h01);
        check_val("async_dir",  32'(dir),  32'd1);
        check_val("async_tick", 32'(tick), 32'd0);
        cycle();
        reset = 1'b0;

        // Randomised mix of modes, divisors and enable gaps.
        for (int seg = 0; seg < 60; seg++) begin
            mode = 2'($urandom_range(0, 3));
            div  = DIV_W'($urandom_range(0, 3));
            for (int c = 0; c < 25; c++) begin
                en = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 19) == 0) div = DIV_W'($urandom_range(0, 3));
                cycle();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
